// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its loader: memory depth,
// word-address bit position and the loader FSM state type.
package imem_pkg;

  localparam int IMEM_DEPTH    = 32;
  localparam int IMEM_ADDR_LSB = 2;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERR,
    CHK
  } loader_state_t;

  // States in which the loader takes bytes from the stream.
  function automatic logic accepts_bytes(input loader_state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: packs four pushed bytes into a little-endian 32-bit word.
// Bytes enter at the top and shift down, so the first byte of a word ends up
// in bits [7:0]. 'full' flags that the next push completes a word.
module word_assembler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        full
);

  logic [1:0]  byte_cnt;
  logic [31:0] shift;

  // Byte counter and shift register; clear drops any partial word.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      byte_cnt <= '0;
      shift    <= '0;
    end else if (push) begin
      byte_cnt <= byte_cnt + 2'd1;
      shift    <= {byte_in, shift[31:8]};
    end
  end

  assign word_out = shift;
  assign full     = (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream, packs it into 32-bit
// words and writes them to instruction memory while holding the core stalled.
// Optional trailing XOR checksum byte is enabled by defining
// IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  // Wide enough to hold DEPTH itself, not just DEPTH-1.
  localparam int CNT_W = $clog2(DEPTH) + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t TAIL = CHK;
`else
  localparam loader_state_t TAIL = DONE;
`endif

  loader_state_t state, state_next;

  logic [7:0]       len_lo;
  logic [15:0]      len_in;
  logic [CNT_W-1:0] n_words;
  logic [CNT_W-1:0] word_idx;
  logic [31:0]      wdata_hold;
  logic [31:0]      asm_word;
  logic             asm_full;
  logic             xfer;
  logic             begin_load;
  logic             last_word;

  assign xfer       = byte_valid && byte_ready;
  assign begin_load = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign len_in     = {byte_data, len_lo};
  assign last_word  = (word_idx == n_words - CNT_W'(1));

  word_assembler u_asm (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (begin_load),
    .push     (xfer && (state == DATA)),
    .byte_in  (byte_data),
    .word_out (asm_word),
    .full     (asm_full)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR of data bytes, restarted with each load.
  always_ff @(posedge clk) begin
    if (!reset_n || begin_load) begin
      csum <= '0;
    end else if (xfer && (state == DATA)) begin
      csum <= csum ^ byte_data;
    end
  end
`endif

  // Next-state decode.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE, ERR: if (start) state_next = LEN_LO;
      LEN_LO:          if (xfer) state_next = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if (len_in > 16'(DEPTH))  state_next = ERR;
          else if (len_in == 16'd0) state_next = TAIL;
          else                      state_next = DATA;
        end
      end
      DATA:            if (xfer && asm_full) state_next = WRITE;
      WRITE:           state_next = last_word ? TAIL : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:             if (xfer) state_next = (byte_data == csum) ? DONE : ERR;
`endif
      default:         state_next = IDLE;
    endcase
  end

  // State register plus outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_next;
      byte_ready <= accepts_bytes(state_next);
      imem_we    <= (state_next == WRITE);
      cpu_hold   <= (state_next != DONE);
      done       <= (state_next == DONE);
      error      <= (state_next == ERR);
      if (state_next == WRITE) begin
        imem_waddr <= 32'(word_idx) << IMEM_ADDR_LSB;
      end
    end
  end

  // Length capture, word index and the held copy of the last written word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      len_lo     <= '0;
      n_words    <= '0;
      word_idx   <= '0;
      wdata_hold <= '0;
    end else begin
      if (xfer && (state == LEN_LO)) len_lo <= byte_data;
      if (xfer && (state == LEN_HI)) n_words <= len_in[CNT_W-1:0];
      if (begin_load) begin
        word_idx <= '0;
      end else if (state == WRITE) begin
        word_idx <= word_idx + CNT_W'(1);
      end
      if (state == WRITE) wdata_hold <= asm_word;
    end
  end

  // The assembled word is complete and stable for the whole WRITE cycle;
  // outside WRITE the last written word is presented unchanged.
  assign imem_wdata = (state == WRITE) ? asm_word : wdata_hold;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives byte streams, logs every memory write
// and checks outputs against hand-computed values.
module tb_imem_loader;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int vectors = 0;
  int miscompares = 0;
  int base;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(IMEM_DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  // Write log, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_waddr);
      wr_data.push_back(imem_wdata);
      $display("write addr=0x%08h data=0x%08h", imem_waddr, imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < wr_addr.size()) begin
      check({tag, "_addr"}, wr_addr[idx], a);
      check({tag, "_data"}, wr_data[idx], d);
    end else begin
      check({tag, "_missing"}, 32'(wr_addr.size()), 32'(idx + 1));
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("byte_accept_timeout", 32'(t < 50), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Checksum byte when the feature is built in; otherwise just let WRITE finish.
  task automatic send_tail(input logic [7:0] c);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(c);
`else
    if (c == 8'hFF) $display("note: tail byte unused");
    @(negedge clk);
`endif
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_imem_we",    32'(imem_we),    32'd0);
    check("rst_waddr",      imem_waddr,      32'h0);
    check("rst_wdata",      imem_wdata,      32'h0);
    check("rst_cpu_hold",   32'(cpu_hold),   32'd1);
    check("rst_done",       32'(done),       32'd0);
    check("rst_error",      32'(error),      32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single word 0x00A00513 at address 0
    base = wr_addr.size();
    pulse_start();
    check("t1_ready_len", 32'(byte_ready), 32'd1);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
    check("t1_we_cycle",  32'(imem_we),  32'd1);
    check("t1_we_addr",   imem_waddr,    32'h0);
    check("t1_we_data",   imem_wdata,    32'h00A00513);
    check("t1_ready_wr",  32'(byte_ready), 32'd0);
    send_tail(8'hB6);
    check("t1_done",      32'(done),     32'd1);
    check("t1_hold",      32'(cpu_hold), 32'd0);
    check("t1_we_low",    32'(imem_we),  32'd0);
    check("t1_ready",     32'(byte_ready), 32'd0);
    check("t1_wdata_hold", imem_wdata,   32'h00A00513);
    check("t1_nwrites",   32'(wr_addr.size() - base), 32'd1);

    // N=3 with byte_valid toggling
    base = wr_addr.size();
    pulse_start();
    check("t2_done_clr", 32'(done),     32'd0);
    check("t2_hold",     32'(cpu_hold), 32'd1);
    send_byte(8'h03); @(negedge clk); send_byte(8'h00); @(negedge clk);
    send_byte(8'h00); @(negedge clk); send_byte(8'h01); @(negedge clk);
    send_byte(8'h02); @(negedge clk); send_byte(8'h03); @(negedge clk);
    send_byte(8'h10); @(negedge clk); send_byte(8'h11); @(negedge clk);
    send_byte(8'h12); @(negedge clk); send_byte(8'h13); @(negedge clk);
    send_byte(8'hA1); @(negedge clk); send_byte(8'hB2); @(negedge clk);
    send_byte(8'hC3); @(negedge clk); send_byte(8'hD4);
    send_tail(8'h04);
    repeat (2) @(negedge clk);
    check("t2_nwrites", 32'(wr_addr.size() - base), 32'd3);
    check_write("t2_w0", base,     32'h0, 32'h03020100);
    check_write("t2_w1", base + 1, 32'h4, 32'h13121110);
    check_write("t2_w2", base + 2, 32'h8, 32'hD4C3B2A1);
    check("t2_done", 32'(done), 32'd1);

    // N=33 exceeds depth
    base = wr_addr.size();
    pulse_start();
    send_byte(8'h21); send_byte(8'h00);
    check("t3_error", 32'(error),      32'd1);
    check("t3_ready", 32'(byte_ready), 32'd0);
    check("t3_hold",  32'(cpu_hold),   32'd1);
    check("t3_done",  32'(done),       32'd0);
    repeat (3) @(negedge clk);
    check("t3_nwrites",     32'(wr_addr.size() - base), 32'd0);
    check("t3_error_stick", 32'(error), 32'd1);
    check("t3_waddr_hold",  imem_waddr, 32'h8);

    // Reset in the middle of word 1
    base = wr_addr.size();
    pulse_start();
    check("t4_error_clr", 32'(error), 32'd0);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    reset_n = 1'b0;
    @(negedge clk);
    check("t4_rst_ready", 32'(byte_ready), 32'd0);
    check("t4_rst_hold",  32'(cpu_hold),   32'd1);
    check("t4_rst_we",    32'(imem_we),    32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_nwrites_abort", 32'(wr_addr.size() - base), 32'd1);
    check_write("t4_w0", base, 32'h0, 32'h44332211);
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    send_tail(8'h22);
    repeat (2) @(negedge clk);
    check("t4_nwrites", 32'(wr_addr.size() - base), 32'd2);
    check_write("t4_w1", base + 1, 32'h0, 32'hEFBEADDE);
    check("t4_done", 32'(done), 32'd1);

    // start during DATA is ignored
    base = wr_addr.size();
    pulse_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02);
    pulse_start();
    send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    send_tail(8'h08);
    repeat (2) @(negedge clk);
    check("t5_nwrites", 32'(wr_addr.size() - base), 32'd2);
    check_write("t5_w0", base,     32'h0, 32'h04030201);
    check_write("t5_w1", base + 1, 32'h4, 32'h08070605);
    check("t5_done", 32'(done), 32'd1);

    // N=0 completes with no writes
    base = wr_addr.size();
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t6_hold_chk", 32'(cpu_hold), 32'd1);
    send_byte(8'h00);
`endif
    check("t6_done",    32'(done),     32'd1);
    check("t6_hold",    32'(cpu_hold), 32'd0);
    check("t6_nwrites", 32'(wr_addr.size() - base), 32'd0);

    // N=DEPTH, word i holds byte i+1 four times
    base = wr_addr.size();
    pulse_start();
    send_byte(8'h20); send_byte(8'h00);
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) send_byte(8'(i + 1));
    end
    send_tail(8'h00);
    repeat (2) @(negedge clk);
    check("t7_nwrites", 32'(wr_addr.size() - base), 32'd32);
    check_write("t7_first", base,      32'h0,  32'h01010101);
    check_write("t7_last",  base + 31, 32'h7C, 32'h20202020);
    check("t7_done",  32'(done),  32'd1);
    check("t7_error", 32'(error), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum match and mismatch
    base = wr_addr.size();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    @(negedge clk);
    check("t8_hold_chk", 32'(cpu_hold), 32'd1);
    check("t8_done_chk", 32'(done),     32'd0);
    send_byte(8'h44);
    check("t8_done", 32'(done), 32'd1);
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h45);
    check("t8_error", 32'(error), 32'd1);
    check("t8_nwrites", 32'(wr_addr.size() - base), 32'd2);
    check_write("t8_w_bad", base + 1, 32'h0, 32'h44332211);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
